// File: rtl/rename_ckpt.sv
// Register-rename stage: map table, circular free list and NUM_CKPT branch checkpoints.
// Optional macro RENAME_COMMIT2_EN adds a second commit port (commit1_valid/commit1_pd_old).
module rename_ckpt #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 128,
  parameter int unsigned ROB_TAG_W = 4,
  parameter int unsigned NUM_CKPT  = 4,
  localparam int unsigned AW = $clog2(ARCH_REGS),
  localparam int unsigned PW = $clog2(PHYS_REGS),
  localparam int unsigned CW = $clog2(NUM_CKPT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_wr,
  input  logic                 in_branch,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [PW-1:0]        out_ps1,
  output logic [PW-1:0]        out_ps2,
  output logic [PW-1:0]        out_pd_new,
  output logic [PW-1:0]        out_pd_old,
  output logic [ROB_TAG_W-1:0] out_rob_tag,
  output logic [CW-1:0]        out_ckpt_id,
  input  logic                 commit_valid,
  input  logic [PW-1:0]        commit_pd_old,
`ifdef RENAME_COMMIT2_EN
  input  logic                 commit1_valid,
  input  logic [PW-1:0]        commit1_pd_old,
`endif
  input  logic                 resolve_valid,
  input  logic                 mispredict,
  input  logic [CW-1:0]        mispredict_ckpt
);

  logic [PW-1:0]        map_q     [ARCH_REGS];
  logic [PW-1:0]        map_upd   [ARCH_REGS];
  logic [PW-1:0]        fl_q      [PHYS_REGS];
  logic [PW:0]          fl_head_q, fl_tail_q, fl_head_nxt, fl_tail_nxt, tail1;
  logic [PW:0]          free_count;
  logic [ROB_TAG_W-1:0] tag_q;
  logic [PW-1:0]        ck_map_q  [NUM_CKPT][ARCH_REGS];
  logic [PW:0]          ck_head_q [NUM_CKPT];
  logic [ROB_TAG_W-1:0] ck_tag_q  [NUM_CKPT];
  logic [CW-1:0]        ck_rd_q, ck_wr_q;
  logic [CW:0]          ck_cnt_q, ck_cnt_d, ck_keep;
  logic                 alloc, accept, c0, c1;
  logic [PW-1:0]        pd_new;

  // Pointers carry a wrap bit above the index; the index wraps at PHYS_REGS.
  function automatic logic [PW:0] fl_inc(input logic [PW:0] p);
    if (p[PW-1:0] == PW'(PHYS_REGS - 1)) return {~p[PW], {PW{1'b0}}};
    return {p[PW], p[PW-1:0] + PW'(1)};
  endfunction

  function automatic logic [CW-1:0] ck_inc(input logic [CW-1:0] p);
    return (p == CW'(NUM_CKPT - 1)) ? '0 : p + CW'(1);
  endfunction

  always_comb begin
    if (fl_head_q[PW] == fl_tail_q[PW])
      free_count = {1'b0, fl_tail_q[PW-1:0]} - {1'b0, fl_head_q[PW-1:0]};
    else
      free_count = (PW+1)'(PHYS_REGS) + {1'b0, fl_tail_q[PW-1:0]} - {1'b0, fl_head_q[PW-1:0]};
  end

  assign alloc    = in_wr && (in_rd != '0);
  assign ready_in = (!valid_out || ready_out) && (!alloc || free_count != '0) &&
                    (!in_branch || ck_cnt_q != (CW+1)'(NUM_CKPT)) && !mispredict;
  assign accept   = valid_in && ready_in;
  assign pd_new   = alloc ? fl_q[fl_head_q[PW-1:0]] : '0;
  assign fl_head_nxt = (accept && alloc) ? fl_inc(fl_head_q) : fl_head_q;

  always_comb begin
    map_upd = map_q;
    if (accept && alloc) map_upd[in_rd] = pd_new;
  end

  assign c0 = commit_valid && (commit_pd_old != '0);
`ifdef RENAME_COMMIT2_EN
  assign c1 = commit1_valid && (commit1_pd_old != '0);
`else
  assign c1 = 1'b0;
`endif
  assign tail1       = fl_inc(fl_tail_q);
  assign fl_tail_nxt = (c0 && c1) ? fl_inc(tail1) : (c0 || c1) ? tail1 : fl_tail_q;

  // On mispredict only the checkpoints older than the restored one survive.
  always_comb begin
    if (mispredict_ckpt >= ck_rd_q)
      ck_keep = {1'b0, mispredict_ckpt} - {1'b0, ck_rd_q};
    else
      ck_keep = {1'b0, mispredict_ckpt} + (CW+1)'(NUM_CKPT) - {1'b0, ck_rd_q};
    if (mispredict) ck_cnt_d = ck_keep;
    else            ck_cnt_d = ck_cnt_q + (CW+1)'(accept && in_branch);
    if (resolve_valid) ck_cnt_d = ck_cnt_d - (CW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) fl_q[i] <= PW'((i + ARCH_REGS) % PHYS_REGS);
      fl_head_q <= '0;
      fl_tail_q <= (PW+1)'(PHYS_REGS - ARCH_REGS);
      tag_q     <= '0;
      ck_rd_q   <= '0;
      ck_wr_q   <= '0;
      ck_cnt_q  <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        ck_head_q[i] <= '0;
        ck_tag_q[i]  <= '0;
        for (int j = 0; j < ARCH_REGS; j++) ck_map_q[i][j] <= '0;
      end
      valid_out   <= 1'b0;
      out_ps1     <= '0;
      out_ps2     <= '0;
      out_pd_new  <= '0;
      out_pd_old  <= '0;
      out_rob_tag <= '0;
      out_ckpt_id <= '0;
    end else begin
      if (c0) fl_q[fl_tail_q[PW-1:0]] <= commit_pd_old;
`ifdef RENAME_COMMIT2_EN
      if (c1) fl_q[c0 ? tail1[PW-1:0] : fl_tail_q[PW-1:0]] <= commit1_pd_old;
`endif
      fl_tail_q <= fl_tail_nxt;
      ck_cnt_q  <= ck_cnt_d;
      if (resolve_valid) ck_rd_q <= ck_inc(ck_rd_q);
      if (mispredict) begin
        map_q     <= ck_map_q[mispredict_ckpt];
        fl_head_q <= ck_head_q[mispredict_ckpt];
        tag_q     <= ck_tag_q[mispredict_ckpt];
        ck_wr_q   <= mispredict_ckpt;
        valid_out <= 1'b0;
      end else if (accept) begin
        map_q       <= map_upd;
        fl_head_q   <= fl_head_nxt;
        tag_q       <= tag_q + ROB_TAG_W'(1);
        valid_out   <= 1'b1;
        out_ps1     <= map_q[in_rs1];
        out_ps2     <= map_q[in_rs2];
        out_pd_new  <= pd_new;
        out_pd_old  <= map_q[in_rd];
        out_rob_tag <= tag_q;
        out_ckpt_id <= in_branch ? ck_wr_q : '0;
        if (in_branch) begin
          ck_map_q[ck_wr_q]  <= map_upd;
          ck_head_q[ck_wr_q] <= fl_head_nxt;
          ck_tag_q[ck_wr_q]  <= tag_q + ROB_TAG_W'(1);
          ck_wr_q            <= ck_inc(ck_wr_q);
        end
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rename_ckpt.md
Name: rename_ckpt

Overview:
Parametrised register-rename stage that sits between decode (skid buffer) and dispatch.
- Maps architectural sources and destinations to physical registers.
- Allocates new physical destinations from an integrated circular free list and returns freed registers on commit.
- Holds NUM_CKPT branch checkpoints, so several unresolved branches can be in flight; any one of them can be rolled back in a single cycle on mispredict.

Parameters:
ARCH_REGS, 32, number of architectural registers (register 0 is hard zero)
PHYS_REGS, 128, number of physical registers (must be > ARCH_REGS)
ROB_TAG_W, 4, width of the ROB tag counter
NUM_CKPT, 4, number of branch checkpoints

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
valid_in  in  1  upstream instruction valid
ready_in  out  1  stage can accept the instruction
in_rs1, in_rs2, in_rd  in  clog2(ARCH_REGS) each  architectural register indices
in_wr  in  1  instruction writes rd (a store or branch drives 0)
in_branch  in  1  instruction needs a checkpoint
valid_out  out  1  output register valid
ready_out  in  1  downstream accepts
out_ps1, out_ps2, out_pd_new, out_pd_old  out  clog2(PHYS_REGS) each  renamed registers
out_rob_tag  out  ROB_TAG_W  ROB tag
out_ckpt_id  out  clog2(NUM_CKPT)  checkpoint assigned (branches only)
commit_valid  in  1  ROB retires a writer
commit_pd_old  in  clog2(PHYS_REGS)  register to free
resolve_valid  in  1  oldest checkpoint's branch resolved correctly
mispredict  in  1  roll back
mispredict_ckpt  in  clog2(NUM_CKPT)  checkpoint to restore

Behaviour:
- Reset (asynchronous) puts the block in this state:
  - map[i]=i.
  - Free list holds ARCH_REGS..PHYS_REGS-1 in ascending order; head=0, tail=PHYS_REGS-ARCH_REGS, count=PHYS_REGS-ARCH_REGS.
  - Tag counter=0; checkpoint FIFO empty.
  - valid_out=0; all out_* buses = 0.
- alloc = in_wr && in_rd!=0.
- ready_in = (!valid_out || ready_out) && (!alloc || free_count>0) && (!in_branch || ckpt_count<NUM_CKPT) && !mispredict.
- Accept = valid_in && ready_in. On accept the output register loads on the next edge (latency 1):
  - out_ps1/out_ps2/out_pd_old = map[rs1]/map[rs2]/map[rd], read before this instruction's own update.
  - out_pd_new = freelist[head] if alloc, else 0; head++.
  - map[rd] <= pd_new.
  - out_rob_tag = counter; counter increments mod 2^ROB_TAG_W.
  - valid_out <= 1.
- No accept and ready_out high: valid_out <= 0. Output is held stable while valid_out && !ready_out.
- Branch accept: checkpoint slot ckpt_tail captures the map (including this cycle's update; a branch never allocates), free-list head after this cycle, and tag+1. out_ckpt_id=ckpt_tail; ckpt_tail++.
- Commit: commit_valid && commit_pd_old!=0 writes freelist[tail], tail++. commit_pd_old=0 is ignored. Commit is applied every cycle, including mispredict cycles.
- resolve_valid: ckpt_head++ (branches resolve in order).
- Mispredict (priority over rename):
  - map, free-list head and tag counter are restored from checkpoint mispredict_ckpt.
  - ckpt_tail <= mispredict_ckpt, which frees that checkpoint and all younger ones.
  - valid_out <= 0.
  - A same-cycle resolve still advances ckpt_head; the bench guarantees resolve targets an older checkpoint.
- Free count = tail-head using pointers one bit wider than the index; the count must never exceed PHYS_REGS-1. Wrap-around occurs at PHYS_REGS.
- Allocation and commit in the same cycle, including with count=0, are legal: the alloc stalls on the old count.

Optional Feature:
RENAME_COMMIT2_EN:
- Defined: adds ports commit1_valid and commit1_pd_old. Two registers can be freed per cycle; port 0 is written first, at tail, and port 1 at tail+1 (or at tail if port 0 is idle).
- Undefined: single commit port only, identical to the behaviour above.

Test Plan:
1. Reset, rename rd=5 in_wr=1 -> pd_new=32, pd_old=5, rob_tag=0; then rs1=5 rd=5 -> ps1=32, pd_new=33, pd_old=32, rob_tag=1.
2. 96 allocating renames, no commits -> 97th with rd=3: ready_in=0. rd=0 / in_wr=0 instruction still accepted with pd_new=0. Commit pd 5 -> next alloc gets pd_new=5.
3. Branch accepted at tag 3 (ckpt 0), then rd=7 gets 34 and rd=8 gets 35; mispredict ckpt 0 -> valid_out=0, map[7]=7, next rd=9 gets pd_new=34 and rob_tag=4.
4. Four branches outstanding -> fifth branch: ready_in=0; resolve_valid one cycle -> fifth accepted with ckpt_id=0.
5. valid_out=1, ready_out=0 for 5 cycles -> outputs stable and ready_in=0; ready_out=1 -> next instruction loads.
6. Assert reset mid-stream, between clock edges -> valid_out=0 immediately; first rename after release gets pd_new=32, tag=0.
